// File: rtl/gcd.sv
// Iterative binary GCD (Stein's algorithm), one reduction step per clock.
// Operands are latched on start; done/result are registered and hold until the next accepted start.
module gcd #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [5:0]       k_q, k_d;
  logic             done_q, done_d;

  logic a_zero, b_zero, a_even, b_even;

  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);
  assign a_even = ~a_q[0];
  assign b_even = ~b_q[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: start is only honoured outside CALC.
  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = CALC;
      CALC:       if (a_zero || b_zero) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath / output next values; priority order of the Stein step matters.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d    = a_in;
          b_d    = b_in;
          k_d    = '0;
          done_d = 1'b0;
        end
      end
      CALC: begin
        if (a_zero) begin
          result_d = b_q << k_q;
          done_d   = 1'b1;
        end else if (b_zero) begin
          result_d = a_q << k_q;
          done_d   = 1'b1;
        end else if (a_even && b_even) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + 6'd1;
        end else if (a_even) begin
          a_d = a_q >> 1;
        end else if (b_even) begin
          b_d = b_q >> 1;
        end else if (a_q >= b_q) begin
          a_d = (a_q - b_q) >> 1;
        end else begin
          b_d = (b_q - a_q) >> 1;
        end
      end
      default: ;
    endcase
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_gcd.sv
// Directed bench for gcd: the driver pushes expected results into a scoreboard
// queue; a monitor pops and compares on each rising edge of done.
module tb_gcd;

  localparam int unsigned WIDTH   = 32;
  localparam int          MAX_CALC = 66;

  typedef struct {
    logic [WIDTH-1:0] exp;
    int               issue_cyc;
    string            name;
  } sb_entry_t;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             done;
  logic [WIDTH-1:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  sb_entry_t sb_q[$];

  gcd #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every rising edge of done must match the oldest pending entry.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, result, e.exp);
        check({e.name, "_calc_cycles_ok"}, ((cyc - e.issue_cyc - 1) <= MAX_CALC), 1);
      end
    end
    done_prev <= done;
  end

  // Present operands for one cycle; the accepting edge is the next posedge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit expect_it, input logic [WIDTH-1:0] exp, input string name);
    sb_entry_t e;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    if (expect_it) begin
      e.exp       = exp;
      e.issue_cyc = cyc;
      e.name      = name;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_reached"}, done, 1);
  endtask

  // Operand inputs wiggle while not accepted; result must stay put.
  task automatic hold_check(input string name, input logic [WIDTH-1:0] exp);
    repeat (3) begin
      @(negedge clk);
      a_in = $urandom;
      b_in = $urandom;
    end
    check({name, "_hold_done"}, done, 1);
    check({name, "_hold_result"}, result, exp);
  endtask

  task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] exp, input string name);
    issue(a, b, 1'b1, exp, name);
    wait_done(name);
    hold_check(name, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    repeat (2) @(negedge clk);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    // start while in reset is ignored
    start = 1'b1;
    a_in  = 32'd48;
    b_in  = 32'd18;
    @(negedge clk);
    start   = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("start_in_reset_ignored", done, 0);

    run(32'd48, 32'd18, 32'd6, "g48_18");
    run(32'd0,  32'd7,  32'd7, "g0_7");
    run(32'd7,  32'd0,  32'd7, "g7_0");
    run(32'd0,  32'd0,  32'd0, "g0_0");
    run(32'd4294967295, 32'd65535, 32'd65535, "gmax_65535");
    run(32'd17, 32'd13, 32'd1, "g17_13");

    // Back-to-back: restart on the first DONE cycle.
    issue(32'd1024, 32'd768, 1'b1, 32'd256, "g1024_768");
    wait_done("g1024_768");
    issue(32'd12, 32'd8, 1'b1, 32'd4, "g12_8");
    check("b2b_done_drops", done, 0);
    wait_done("g12_8");
    hold_check("g12_8", 32'd4);

    // start during CALC must not disturb the running computation.
    issue(32'd100, 32'd75, 1'b1, 32'd25, "g100_75");
    start = 1'b1;
    a_in  = 32'd9;
    b_in  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("g100_75");
    hold_check("g100_75", 32'd25);

    // Reset mid-CALC aborts with no done pulse.
    issue(32'd4294967295, 32'd1, 1'b0, '0, "abort");
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midcalc_reset_done", done, 0);
    check("midcalc_reset_result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_done", done, 0);
    check("abort_result_zero", result, 0);
    run(32'd9, 32'd6, 32'd3, "g9_6");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
